alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 8 bits.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  block can accept a command.
REQ-006 cmd_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 NEG, 7 INC, 8 DEC, 9 ROR, 10 MUL, 11-15 illegal.
REQ-007 cmd_a, cmd_b  in  8 each  operands.
REQ-008 rsp_valid  out  1  result present.
REQ-009 rsp_ready  in  1  consumer takes result.
REQ-010 rsp_lo, rsp_hi  out  8 each  result low byte and high byte; rsp_hi is nonzero only for MUL.
REQ-011 rsp_cf, rsp_zf, rsp_err  out  1 each  carry, zero and illegal-op flags.
REQ-012 alu_a, alu_b  out  8 each  ALU operand drive.
REQ-013 ci, nb, ic, na, xo, no, sr, ss  out  1 each  ALU control drive.
REQ-014 alu_out  in  8;  alu_cf, alu_zf  in  1 each  ALU result and flags.

Function
REQ-015 States SHALL be IDLE, EXEC and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-016 Accept occurs on a clock edge where cmd_valid and cmd_ready are both 1; the block SHALL latch op, a and b and go to EXEC, or to DONE with rsp_err=1 for an illegal op.
REQ-017 Outside EXEC, alu_a, alu_b and all eight controls SHALL be 0.
REQ-018 In EXEC, single-step ops SHALL drive alu_a=a and alu_b=b with these controls set (all others 0):
  - ADD: none
  - SUB: ci, nb
  - AND: ic, na, nb, no, xo
  - OR: ic, xo
  - XOR: ic
  - NOT: nb, ic
  - NEG: na, ci
  - INC: ci
  - DEC: nb
  - ROR: sr
REQ-019 For NOT, NEG, INC and DEC, alu_b SHALL be 0; for ROR, alu_b SHALL be {5'b0, b[2:0]}; ss SHALL always be 0.
REQ-020 Single-step ops SHALL spend exactly one cycle in EXEC; at its end the block SHALL capture rsp_lo=alu_out, rsp_hi=0, rsp_cf=alu_cf, rsp_zf=alu_zf, rsp_err=0, and go to DONE.
REQ-021 MUL SHALL be a shift-add over exactly 8 EXEC cycles, with internal registers P_hi=0, P_lo=b and multiplicand M=a at accept.
REQ-022 Each MUL cycle SHALL drive ADD controls (all 0) with alu_a=P_hi and alu_b=(P_lo[0] ? M : 0), then update {P_hi,P_lo} <= {alu_cf, alu_out, P_lo} >> 1.
REQ-023 MUL SHALL complete with rsp_lo=P_lo, rsp_hi=P_hi, rsp_cf=(P_hi!=0), rsp_zf=(16-bit product==0), rsp_err=0.
REQ-024 Latency, counting from the accept edge k: rsp_valid SHALL rise after edge k+2 for single-step ops, after edge k+9 for MUL, and after edge k+1 for illegal ops.
REQ-025 In DONE, rsp_valid=1 and all rsp_* outputs SHALL be held stable until rsp_ready=1, then the block returns to IDLE on that edge; the next accept is possible no earlier than the following edge.
REQ-026 An illegal op SHALL produce rsp_lo=0, rsp_hi=0, rsp_cf=0, rsp_zf=0, rsp_err=1, and no ALU control SHALL be asserted for it.
REQ-027 The MUL iteration counter SHALL be 3 bits, SHALL wrap 7->0 exactly at the end of the last iteration, and SHALL never be observable.
REQ-028 rsp_valid SHALL be 0 whenever the state is not DONE.

Reset
REQ-029 While rst=1 at an edge, the block SHALL go to IDLE and clear state, counter, operands and P; it SHALL set rsp_valid=0, rsp_lo=0, rsp_hi=0 and rsp_cf=rsp_zf=rsp_err=0; after that edge cmd_ready=1 and all ALU drives are 0.
REQ-030 rst SHALL take priority over an accept and over rsp_ready in the same cycle, and reset mid-EXEC or in DONE SHALL discard the operation with no response.

Verification
REQ-031 ADD a=254,b=2 accepted at edge k -> rsp_valid after k+2 with rsp_lo=0, rsp_cf=1, rsp_zf=1, rsp_err=0.
REQ-032 SUB a=10,b=4 -> during EXEC ci=1, nb=1 and other controls 0 -> rsp_lo=6.
REQ-033 MUL 13*11 -> rsp_hi=0x00, rsp_lo=0x8F, rsp_cf=0; then MUL 255*255 -> rsp_hi=0xFE, rsp_lo=0x01, rsp_cf=1, rsp_valid after edge k+9.
REQ-034 AND a=10,b=9 with rsp_ready held 0 for 3 cycles -> rsp_lo=8 stable, cmd_ready=0 throughout; a command waiting at handshake is accepted one edge later.
REQ-035 rst pulsed on the 4th MUL EXEC cycle -> next cycle cmd_ready=1, rsp_valid=0, ALU drives 0, and no response ever appears.
REQ-036 Illegal op 15, then ROR a=4,b=7 -> first response rsp_err=1 with lo/hi=0 after edge k+1; ROR shows sr=1, alu_b=7 and rsp_lo=8.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencer that drives an external 8-bit ALU one command at a time.
// Single-step ops take one EXEC cycle; MUL is an 8-cycle shift-add through the same ALU.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_lo,
  output logic [7:0] rsp_hi,
  output logic       rsp_cf,
  output logic       rsp_zf,
  output logic       rsp_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       ci,
  output logic       nb,
  output logic       ic,
  output logic       na,
  output logic       xo,
  output logic       no,
  output logic       sr,
  output logic       ss,
  input  logic [7:0] alu_out,
  input  logic       alu_cf,
  input  logic       alu_zf
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_DEC = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  p_hi;
  logic [7:0]  p_lo;
  logic [2:0]  cnt;
  logic        legal;
  logic        last_iter;
  logic [16:0] mul_step;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and outputs stay frozen while valid waits for ready.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign legal     = (cmd_op <= OP_MUL);
  assign last_iter = (op_q != OP_MUL) || (cnt == 3'd7);
  assign mul_step  = {alu_cf, alu_out, p_lo};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = legal ? EXEC : DONE;
      EXEC: if (last_iter) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU drive: everything is 0 except while executing a legal op.
  always_comb begin
    alu_a = 8'd0;
    alu_b = 8'd0;
    {ci, nb, ic, na, xo, no, sr, ss} = 8'd0;
    if (state == EXEC) begin
      alu_a = a_q;
      alu_b = b_q;
      case (op_q)
        OP_ADD: ;
        OP_SUB: {ci, nb} = 2'b11;
        OP_AND: {ic, na, nb, no, xo} = 5'b11111;
        OP_OR:  {ic, xo} = 2'b11;
        OP_XOR: ic = 1'b1;
        OP_NOT: begin {nb, ic} = 2'b11; alu_b = 8'd0; end
        OP_NEG: begin {na, ci} = 2'b11; alu_b = 8'd0; end
        OP_INC: begin ci = 1'b1; alu_b = 8'd0; end
        OP_DEC: begin nb = 1'b1; alu_b = 8'd0; end
        OP_ROR: begin sr = 1'b1; alu_b = {5'd0, b_q[2:0]}; end
        OP_MUL: begin
          alu_a = p_hi;
          alu_b = p_lo[0] ? a_q : 8'd0;
        end
        default: begin alu_a = 8'd0; alu_b = 8'd0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 4'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      p_hi    <= 8'd0;
      p_lo    <= 8'd0;
      cnt     <= 3'd0;
      rsp_lo  <= 8'd0;
      rsp_hi  <= 8'd0;
      rsp_cf  <= 1'b0;
      rsp_zf  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_q <= cmd_op;
          a_q  <= cmd_a;
          b_q  <= cmd_b;
          p_hi <= 8'd0;
          p_lo <= cmd_b;
          cnt  <= 3'd0;
          if (!legal) begin
            rsp_lo  <= 8'd0;
            rsp_hi  <= 8'd0;
            rsp_cf  <= 1'b0;
            rsp_zf  <= 1'b0;
            rsp_err <= 1'b1;
          end
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            // Product shifts right one bit per pass; cnt wraps 7->0 on the last pass.
            {p_hi, p_lo} <= mul_step[16:1];
            cnt          <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rsp_lo  <= mul_step[8:1];
              rsp_hi  <= mul_step[16:9];
              rsp_cf  <= (mul_step[16:9] != 8'd0);
              rsp_zf  <= (mul_step[16:1] == 16'd0);
              rsp_err <= 1'b0;
            end
          end else begin
            rsp_lo  <= alu_out;
            rsp_hi  <= 8'd0;
            rsp_cf  <= alu_cf;
            rsp_zf  <= alu_zf;
            rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU on the drive pins, randomized and directed commands,
// scoreboard of expected responses checked by an independent monitor.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_lo, rsp_hi;
  logic       rsp_cf, rsp_zf, rsp_err;
  logic [7:0] alu_a, alu_b;
  logic       ci, nb, ic, na, xo, no, sr, ss;
  logic [7:0] alu_out;
  logic       alu_cf, alu_zf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [18:0] exp_q[$];
  int          acc_q[$];
  int          lat_q[$];
  int          stall_q[$];
  bit          have = 0;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b),
    .ci(ci), .nb(nb), .ic(ic), .na(na), .xo(xo), .no(no), .sr(sr), .ss(ss),
    .alu_out(alu_out), .alu_cf(alu_cf), .alu_zf(alu_zf)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external ALU: inverters on inputs, adder or logic unit, optional output inverter, rotator
  always_comb begin
    logic [7:0] xa, xb, r;
    logic [8:0] s;
    xa = na ? ~alu_a : alu_a;
    xb = nb ? ~alu_b : alu_b;
    alu_cf = 1'b0;
    if (sr) begin
      s = 9'd0;
      r = 8'(({alu_a, alu_a}) >> alu_b[2:0]);
    end else if (ic) begin
      s = 9'd0;
      r = xo ? (xa | xb) : (xa ^ xb);
    end else begin
      s = {1'b0, xa} + {1'b0, xb} + {8'd0, ci};
      r = s[7:0];
      alu_cf = s[8];
    end
    alu_out = no ? ~r : r;
    alu_zf  = (alu_out == 8'd0);
  end

  function automatic logic [7:0] ctl();
    return {ci, nb, ic, na, xo, no, sr, ss};
  endfunction

  // expected response {err, zf, cf, hi, lo} from plain arithmetic
  function automatic logic [18:0] ref_rsp(input logic [3:0] op, input logic [7:0] a, b);
    logic [7:0] lo, hi;
    logic cf;
    logic [15:0] p, aa;
    hi = 8'd0; cf = 1'b0;
    case (op)
      4'd0: begin p = 16'(a) + 16'(b); lo = p[7:0]; cf = p[8]; end
      4'd1: begin lo = a - b; cf = (a >= b); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = a ^ b;
      4'd5: lo = ~a;
      4'd6: begin lo = 8'd0 - a; cf = (a == 8'd0); end
      4'd7: begin lo = a + 8'd1; cf = (a == 8'd255); end
      4'd8: begin lo = a - 8'd1; cf = (a != 8'd0); end
      4'd9: begin aa = {a, a}; aa = aa >> b[2:0]; lo = aa[7:0]; end
      4'd10: begin
        p = 16'(a) * 16'(b);
        return {1'b0, (p == 16'd0), (p[15:8] != 8'd0), p[15:8], p[7:0]};
      end
      default: return {1'b1, 18'd0};
    endcase
    return {1'b0, (lo == 8'd0), cf, hi, lo};
  endfunction

  function automatic logic [7:0] exp_ctl(input logic [3:0] op);
    case (op) //            ci nb ic na xo no sr ss
      4'd1:  return 8'b1100_0000;
      4'd2:  return 8'b0111_1100;
      4'd3:  return 8'b0010_1000;
      4'd4:  return 8'b0010_0000;
      4'd5:  return 8'b0110_0000;
      4'd6:  return 8'b1001_0000;
      4'd7:  return 8'b1000_0000;
      4'd8:  return 8'b0100_0000;
      4'd9:  return 8'b0000_0010;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // driver: present a command, hold it until accepted, queue its expectation, check EXEC drive
  task automatic issue(input logic [3:0] op, input logic [7:0] a, b, input int stall,
                       input bit expect_rsp);
    int guard;
    logic [7:0] eb;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    guard = 0;
    while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (expect_rsp) begin
      exp_q.push_back(ref_rsp(op, a, b));
      acc_q.push_back(cyc + 1);
      lat_q.push_back(op > 4'd10 ? 1 : (op == 4'd10 ? 9 : 2));
      stall_q.push_back(stall);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom_range(0, 15)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    if (op < 4'd10) begin
      eb = (op >= 4'd5 && op <= 4'd8) ? 8'd0 : (op == 4'd9 ? {5'd0, b[2:0]} : b);
      chk("exec_ctl", ctl(), exp_ctl(op));
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, eb);
      chk("exec_no_rsp", {cmd_ready, rsp_valid}, 2'b00);
    end else if (op == 4'd10 && expect_rsp) begin
      for (int i = 0; i < 8; i++) begin
        chk("mul_ctl", ctl(), 8'd0);
        chk("mul_no_rsp", {cmd_ready, rsp_valid}, 2'b00);
        if (i < 7) @(negedge clk);
      end
    end else if (op > 4'd10) begin
      chk("illegal_drive", {alu_a, alu_b, ctl()}, 24'd0);
    end
  endtask

  // monitor: pop an expectation when a response appears, recheck it each stalled cycle
  initial begin
    logic [18:0] cur;
    int stall_left;
    rsp_ready = 1'b0;
    cur = '0; stall_left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have = 0;
        rsp_ready = 1'b0;
      end else begin
        if (cmd_ready) begin
          chk("idle_drive", {alu_a, alu_b, ctl()}, 24'd0);
          chk("idle_no_rsp", rsp_valid, 1'b0);
        end
        if (rsp_valid) begin
          chk("done_cmd_ready", cmd_ready, 1'b0);
          chk("done_drive", {alu_a, alu_b, ctl()}, 24'd0);
          if (!have) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 32'd1, 32'd0);
              stall_left = -1;
            end else begin
              cur = exp_q.pop_front();
              stall_left = stall_q.pop_front();
              chk("latency", cyc + 1 - acc_q.pop_front(), lat_q.pop_front());
              have = 1;
            end
          end
          if (have) chk("rsp", {rsp_err, rsp_zf, rsp_cf, rsp_hi, rsp_lo}, cur);
          if (stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
          end else begin
            rsp_ready = 1'b1;
            have = 0;
          end
        end else begin
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin
    int guard;
    logic [3:0] op;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_zf, rsp_cf, rsp_hi, rsp_lo}, 20'd0);
    chk("reset_drive", {alu_a, alu_b, ctl()}, 24'd0);
    rst = 1'b0;

    // directed cases
    issue(4'd0, 8'd254, 8'd2, 0, 1);
    issue(4'd1, 8'd10, 8'd4, 1, 1);
    issue(4'd10, 8'd13, 8'd11, 0, 1);
    issue(4'd10, 8'd255, 8'd255, 2, 1);
    issue(4'd2, 8'd10, 8'd9, 3, 1);
    issue(4'd4, 8'h5a, 8'h0f, 0, 1);
    issue(4'd15, 8'd77, 8'd88, 1, 1);
    issue(4'd9, 8'd4, 8'd7, 0, 1);
    issue(4'd10, 8'd0, 8'd200, 0, 1);
    issue(4'd6, 8'd0, 8'd0, 0, 1);
    issue(4'd8, 8'd0, 8'd0, 0, 1);
    issue(4'd7, 8'd255, 8'd0, 0, 1);

    // reset on the 4th MUL EXEC cycle discards the operation
    guard = 0;
    while ((exp_q.size() != 0 || have) && guard < 200) begin @(negedge clk); guard++; end
    issue(4'd10, 8'd200, 8'd100, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_drive", {alu_a, alu_b, ctl()}, 24'd0);
    repeat (20) @(negedge clk);

    // randomized traffic, mostly legal ops
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      issue(op, 8'($urandom), 8'($urandom), $urandom_range(0, 2), 1);
    end

    guard = 0;
    while ((exp_q.size() != 0 || have) && guard < 500) begin @(negedge clk); guard++; end
    chk("drain_pending", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
